// File: rtl/dmem_responder.sv
// dmem_responder: byte-lane data-memory responder with programmable wait states and stall.
// Define DMEM_RANGE_CHECK_EN to flag and suppress accesses whose upper address bits are nonzero.
module dmem_responder #(
  parameter int ADDR_W = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic [3:0]  req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rsp_rdata,
  output logic        rsp_valid,
  output logic        stall,
  output logic        err
);
`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [3:0] wen_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0] wdata_q;
  logic hi_q;
  logic oor;
  logic [31:0] mem [2**ADDR_W];
  assign oor = RANGE_EN & hi_q;
  assign stall = (state == IDLE && req_en) || state == WAIT || state == ACCESS;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rsp_rdata <= '0;
      rsp_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      rsp_valid <= state == ACCESS;
      err <= state == ACCESS && oor;
      case (state)
        IDLE: if (req_en) begin
          wen_q <= req_wen;
          idx_q <= req_addr[ADDR_W+1:2];
          hi_q <= |req_addr[31:ADDR_W+2];
          wdata_q <= req_wdata;
          cnt <= 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
          state <= WAIT_CYCLES > 0 ? WAIT : ACCESS;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd0) state <= ACCESS;
        end
        ACCESS: begin
          if (wen_q == 4'd0) rsp_rdata <= oor ? 32'h0 : mem[idx_q];
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // RAM is not reset; a reset sampled on the ACCESS edge still blocks the write
  always_ff @(posedge clk) begin
    if (!rst && state == ACCESS && wen_q != 4'd0 && !oor)
      for (int b = 0; b < 4; b++)
        if (wen_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder (WAIT_CYCLES 2 main instance, 0-wait instance).
module tb_dmem_responder;
  localparam int WAITC = 2;
`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif
  typedef struct { logic [31:0] rd; logic e; } exp_t;
  logic clk = 0, rst = 0;
  logic req_en = 0;
  logic [3:0] req_wen = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [31:0] rsp_rdata;
  logic rsp_valid, stall, err;
  logic req_en0 = 0;
  logic [31:0] rsp_rdata0;
  logic rsp_valid0, stall0, err0;
  int checks = 0, failures = 0;
  exp_t sb [$];
  logic [31:0] mdl [1024];
  logic [31:0] mdl_rd = 32'h0;
  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(WAITC)) u_dut (
    .clk(clk), .rst(rst), .req_en(req_en), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_rdata(rsp_rdata), .rsp_valid(rsp_valid), .stall(stall), .err(err));
  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_en(req_en0), .req_wen(4'd0), .req_addr(32'h8),
    .req_wdata(32'h0), .rsp_rdata(rsp_rdata0), .rsp_valid(rsp_valid0), .stall(stall0), .err(err0));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) check("unexpected_valid", 32'(rsp_valid), 32'h0);
      else begin
        exp_t x;
        x = sb.pop_front();
        check("rdata", rsp_rdata, x.rd);
        check("err", 32'(err), 32'(x.e));
      end
    end else if (err !== 1'b0) check("err_idle", 32'(err), 32'h0);
  end
  task automatic txn(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    int n;
    logic oor;
    logic [9:0] idx;
    exp_t x;
    idx = a[11:2];
    oor = RANGE_EN && (a[31:12] != 0);
    if (w == 4'd0) mdl_rd = oor ? 32'h0 : mdl[idx];
    else if (!oor)
      for (int b = 0; b < 4; b++) if (w[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
    x.rd = mdl_rd;
    x.e = oor;
    sb.push_back(x);
    req_en = 1; req_wen = w; req_addr = a; req_wdata = d;
    n = 0;
    @(negedge clk);
    while (stall === 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
      if (n == 1) begin
        req_wen = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
      end
      @(negedge clk);
    end
    check("stall_len", 32'(n), 32'(WAITC + 2));
    @(posedge clk); #1;
    req_en = 0;
    @(negedge clk);
    check("valid_once", 32'(rsp_valid), 32'h0);
    @(posedge clk); #1;
  endtask
  initial begin
    req_en = 1; req_wen = 4'hf; req_addr = 32'h40; req_wdata = 32'h0BADF00D;
    rst = 1;
    repeat (2) begin
      @(negedge clk);
      check("rst_valid", 32'(rsp_valid), 32'h0);
      check("rst_rdata", rsp_rdata, 32'h0);
      check("rst_err", 32'(err), 32'h0);
    end
    @(posedge clk); #1;
    rst = 0;
    #1 check("stall_after_rst", 32'(stall), 32'h1);
    txn(4'hf, 32'h40, 32'h0BADF00D);
    txn(4'hf, 32'h10, 32'hDEADBEEF);
    txn(4'h0, 32'h10, 32'h0);
    txn(4'hf, 32'h20, 32'h11223344);
    txn(4'h1, 32'h20, 32'h000000AA);
    txn(4'hc, 32'h20, 32'hBBBB0000);
    txn(4'h0, 32'h20, 32'h0);
    check("byte_lanes_model", mdl_rd, 32'hBBBB33AA);
    txn(4'h0, 32'h40, 32'h0);
    txn(4'hf, 32'h30, 32'h12345678);
    req_en = 1; req_wen = 4'hf; req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_en = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("abort_stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    txn(4'h0, 32'h30, 32'h0);
    txn(4'hf, 32'h0, 32'hA5A5A5A5);
    txn(4'hf, 32'h1000, 32'h00000055);
    txn(4'h0, 32'h0, 32'h0);
    check("range_model", mdl_rd, RANGE_EN ? 32'hA5A5A5A5 : 32'h00000055);
    req_en0 = 1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("zw_stall", 32'(stall0), 32'(i % 3 != 2));
      check("zw_valid", 32'(rsp_valid0), 32'(i % 3 == 2));
    end
    @(posedge clk); #1;
    req_en0 = 0;
    repeat (3) @(posedge clk);
    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the far side of the CPU's load/store byte-lane interface. It accepts one word-aligned request per transaction, carrying byte-lane write enables, an address and a write word. It performs the byte-masked write or full-word read against an internal word-organised RAM after a programmable number of wait states. It drives a stall back to the memory stage until the access completes.

## Interface
Parameters:
- ADDR_W, 10: word-index width; RAM holds 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 2: extra wait states per access, 0..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_en  in  1  request present; held by the CPU until stall drops.
- req_wen  in  4  byte-lane write enables; bit i writes byte i (bits 8i+7:8i). 4'b0000 means read.
- req_addr  in  32  byte address; bits [1:0] ignored; word index is req_addr[ADDR_W+1:2].
- req_wdata  in  32  write data, already lane-positioned by the CPU.
- rsp_rdata  out  32  full read word (CPU performs byte/half extraction).
- rsp_valid  out  1  one-cycle completion pulse.
- stall  out  1  hold the memory stage.
- err  out  1  out-of-range flag; always present, constant 0 unless the feature in Configuration is compiled in.

## Operation
- FSM states are IDLE, WAIT, ACCESS and DONE.
- IDLE: if req_en = 1, latch req_wen, the word index, the upper address bits and req_wdata. Next state is WAIT (counter loaded with WAIT_CYCLES-1) if WAIT_CYCLES > 0, else ACCESS. If req_en = 0, stay in IDLE.
- WAIT: decrement the counter; go to ACCESS when the counter = 0.
- ACCESS: if the latched wen is nonzero, write only the enabled byte lanes of RAM[index] (other bytes unchanged). If wen = 0, register RAM[index] into rsp_rdata. Next state is DONE.
- DONE: rsp_valid = 1. req_* is ignored (the CPU is still presenting the completed request). Next state is IDLE.
- stall = (state==IDLE && req_en) || state==WAIT || state==ACCESS. This is combinational from req_en in IDLE.
- rsp_rdata changes only on a completed read. It holds across writes and idle cycles.
- RAM contents are not reset.

## Timing
- Reset values: state IDLE, counter 0, rsp_rdata 32'h0, rsp_valid 0, err 0. stall follows req_en in IDLE.
- Stall duration per request is WAIT_CYCLES + 2 cycles (the IDLE accept cycle, the WAIT cycles, and the ACCESS cycle). rsp_valid rises in the following cycle (DONE), with stall = 0.
- Back-to-back requests always have one non-accepting cycle (DONE) between them. Minimum issue interval is WAIT_CYCLES + 3 cycles.
- Write data becomes visible to a read accepted at or after the DONE cycle of the write.
- Reset asserted mid-transaction returns to IDLE on the next edge. A write is suppressed if reset is sampled at or before the ACCESS edge. rsp_valid is not pulsed for an aborted request.
- Changes to req_* after acceptance have no effect; only the latched copy is used.

## Configuration
- DMEM_RANGE_CHECK_EN defined: a request whose latched req_addr[31:ADDR_W+2] is nonzero is out of range.
  - In ACCESS, an out-of-range write is dropped, and an out-of-range read loads rsp_rdata with 32'h0.
  - err = 1 in the DONE cycle, coincident with rsp_valid.
  - err is 0 in every other cycle.
- DMEM_RANGE_CHECK_EN undefined: upper address bits are ignored, so addresses alias modulo 2^(ADDR_W+2) bytes, and err is tied to 0.

## Test plan
- Reset: hold rst for 2 cycles with req_en = 1. Required: rsp_valid = 0, rsp_rdata = 0, err = 0. After release, stall = 1 immediately in IDLE.
- Full-word round trip (WAIT_CYCLES = 2): write 0xDEADBEEF to addr 0x10 with wen 4'b1111, then read 0x10. Required: stall high for exactly 4 cycles per request, rsp_valid pulses once, rsp_rdata = 0xDEADBEEF.
- Byte lanes: write 0x11223344 to 0x20 with wen 1111, then 0x000000AA with wen 0001, then 0xBBBB0000 with wen 1100, then read 0x20. Required: rsp_rdata = 0xBBBB33AA.
- Zero wait states (WAIT_CYCLES = 0): issue back-to-back read requests. Required: stall is 2 cycles per request, and the issue interval is 3 cycles.
- Reset mid-op: start a write of 0xCAFEF00D to 0x30 over a prior value of 0x12345678, and assert rst during WAIT. Then read 0x30. Required: rsp_rdata = 0x12345678, with no rsp_valid for the aborted request.
- Range (macro on, ADDR_W = 10): write 0x55 to byte address 0x1000, then read 0x0. Required: err = 1 with rsp_valid, and word 0 unchanged. With the macro off, the same write aliases to word 0 and err stays 0.
